// File: rtl/bus_fabric.sv
// Registered single-master interconnect: base/mask address decode, req/ready handshake, error on unmapped.
// Optional access watchdog is built only when BUS_TIMEOUT_EN is defined.
module bus_fabric #(
    parameter int                   NSLV     = 3,
    parameter int                   AW       = 32,
    parameter int                   DW       = 32,
    parameter logic [NSLV*AW-1:0]   SLV_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0},
    parameter logic [NSLV*AW-1:0]   SLV_MASK = {3{32'hFFFF_0000}},
    parameter int                   TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m_req,
    input  logic [AW-1:0]        m_addr,
    input  logic [DW-1:0]        m_wdata,
    input  logic                 m_write,
    input  logic [1:0]           m_size,
    output logic                 m_ready,
    output logic [DW-1:0]        m_rdata,
    output logic                 m_err,
    output logic [NSLV-1:0]      s_sel,
    output logic [AW-1:0]        s_addr,
    output logic [DW-1:0]        s_wdata,
    output logic                 s_write,
    output logic [1:0]           s_size,
    input  logic [NSLV*DW-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    generate
        if (NSLV < 1 || NSLV > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
            $error("bus_fabric: NSLV must be 1..8 and TIMEOUT 1..255");
        end
    endgenerate

    state_t             state_q, state_d;
    logic               m_ready_q, m_ready_d;
    logic               m_err_q, m_err_d;
    logic [DW-1:0]      m_rdata_q, m_rdata_d;
    logic [NSLV-1:0]    s_sel_q, s_sel_d;
    logic [AW-1:0]      s_addr_q, s_addr_d;
    logic [DW-1:0]      s_wdata_q, s_wdata_d;
    logic               s_write_q, s_write_d;
    logic [1:0]         s_size_q, s_size_d;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
    logic [7:0]         tmo_cnt_q, tmo_cnt_d;
`endif

    logic [NSLV-1:0]    hit;
    logic [NSLV-1:0]    hit_onehot;
    logic               any_hit;
    logic [DW-1:0]      rdata_masked [NSLV];
    logic [DW-1:0]      sel_rdata;
    logic               sel_ready;

    // Window match per slave, plus read data gated by the registered select.
    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
            assign hit[gi] = (m_addr & SLV_MASK[gi*AW +: AW]) == SLV_BASE[gi*AW +: AW];
            assign rdata_masked[gi] = s_sel_q[gi] ? s_rdata[gi*DW +: DW] : '0;
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the last write.
    always_comb begin
        hit_onehot = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    assign any_hit   = |hit;
    assign sel_ready = |(s_ready & s_sel_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel_rdata = sel_rdata | rdata_masked[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        m_ready_d = 1'b0;
        m_err_d   = 1'b0;
        m_rdata_d = m_rdata_q;
        s_sel_d   = s_sel_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_write_d = s_write_q;
        s_size_d  = s_size_q;
`ifdef BUS_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (m_req) begin
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    s_write_d = m_write;
                    s_size_d  = m_size;
                    if (any_hit) begin
                        s_sel_d = hit_onehot;
                        state_d = ACCESS;
`ifdef BUS_TIMEOUT_EN
                        tmo_cnt_d = 8'd0;
`endif
                    end else begin
                        m_err_d   = 1'b1;
                        m_ready_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    m_rdata_d = s_write_q ? '0 : sel_rdata;
                    m_ready_d = 1'b1;
                    s_sel_d   = '0;
                    state_d   = RESP;
                end
`ifdef BUS_TIMEOUT_EN
                // A slave that answers on the limit cycle still completes normally.
                else if (tmo_cnt_q == TMO_LIMIT) begin
                    m_rdata_d = '0;
                    m_err_d   = 1'b1;
                    m_ready_d = 1'b1;
                    s_sel_d   = '0;
                    state_d   = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                s_sel_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_ready_q <= 1'b0;
            m_err_q   <= 1'b0;
            m_rdata_q <= '0;
            s_sel_q   <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_write_q <= 1'b0;
            s_size_q  <= 2'b00;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            m_ready_q <= m_ready_d;
            m_err_q   <= m_err_d;
            m_rdata_q <= m_rdata_d;
            s_sel_q   <= s_sel_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_write_q <= s_write_d;
            s_size_q  <= s_size_d;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    assign m_ready = m_ready_q;
    assign m_err   = m_err_q;
    assign m_rdata = m_rdata_q;
    assign s_sel   = s_sel_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_write = s_write_q;
    assign s_size  = s_size_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Randomized bench for bus_fabric against a window-decode/latency reference model.
// Slave 2 overlaps slave 1 so that lowest-index priority is exercised.
module tb_bus_fabric;

    localparam int NSLV    = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;
    localparam logic [NSLV*AW-1:0] BASE_FLAT = {32'h1000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NSLV*AW-1:0] MASK_FLAT = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 m_req;
    logic [AW-1:0]        m_addr;
    logic [DW-1:0]        m_wdata;
    logic                 m_write;
    logic [1:0]           m_size;
    logic                 m_ready;
    logic [DW-1:0]        m_rdata;
    logic                 m_err;
    logic [NSLV-1:0]      s_sel;
    logic [AW-1:0]        s_addr;
    logic [DW-1:0]        s_wdata;
    logic                 s_write;
    logic [1:0]           s_size;
    logic [NSLV*DW-1:0]   s_rdata;
    logic [NSLV-1:0]      s_ready;

    int            n_pass  = 0;
    int            n_total = 0;
    logic [DW-1:0] model_rdata = '0;

    always #5 clk = ~clk;

    bus_fabric #(
        .NSLV(NSLV), .AW(AW), .DW(DW),
        .SLV_BASE(BASE_FLAT), .SLV_MASK(MASK_FLAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write), .m_size(m_size),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
        .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_write(s_write), .s_size(s_size),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // First window (lowest index) whose masked address equals its base; -1 if none.
    function automatic int model_decode(input logic [AW-1:0] a);
        for (int i = 0; i < NSLV; i++)
            if ((a & MASK_FLAT[i*AW +: AW]) == BASE_FLAT[i*AW +: AW]) return i;
        return -1;
    endfunction

    function automatic logic [NSLV*DW-1:0] rand_rdata();
        logic [NSLV*DW-1:0] v;
        for (int i = 0; i < NSLV; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    // Called at a negedge with the fabric idle; returns at a negedge with the fabric idle.
    task automatic do_txn(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic wr, input logic [1:0] size, input int waits);
        int              idx;
        int              stop_k;
        bit              tmo;
        logic [DW-1:0]   exp_rd;
        logic [NSLV-1:0] exp_sel;
        idx    = model_decode(addr);
        exp_rd = model_rdata;
        m_req = 1'b1; m_addr = addr; m_wdata = wdata; m_write = wr; m_size = size;
        s_rdata = rand_rdata();
        s_ready = NSLV'($urandom);
        @(negedge clk);
        chk("lat_addr", s_addr, addr);
        chk("lat_wdata", s_wdata, wdata);
        chk("lat_write", s_write, wr);
        chk("lat_size", s_size, size);
        tmo = 1'b0;
        if (idx < 0) begin
            chk("unmap_ready", m_ready, 1);
            chk("unmap_err", m_err, 1);
            chk("unmap_sel", s_sel, 0);
            chk("unmap_rdata", m_rdata, model_rdata);
        end else begin
            exp_sel = '0;
            exp_sel[idx] = 1'b1;
            stop_k = waits;
`ifdef BUS_TIMEOUT_EN
            if (waits > TIMEOUT) begin
                stop_k = TIMEOUT;
                tmo    = 1'b1;
            end
`endif
            for (int k = 0; k <= stop_k; k++) begin
                chk("acc_sel", s_sel, exp_sel);
                chk("acc_ready_low", m_ready, 0);
                chk("acc_addr_hold", s_addr, addr);
                s_rdata = rand_rdata();
                s_ready = NSLV'($urandom);
                s_ready[idx] = (k == waits);
                if (k == waits) exp_rd = wr ? '0 : s_rdata[idx*DW +: DW];
                @(negedge clk);
            end
            if (tmo) exp_rd = '0;
            model_rdata = exp_rd;
            chk("done_ready", m_ready, 1);
            chk("done_err", m_err, tmo);
            chk("done_rdata", m_rdata, model_rdata);
            chk("done_sel", s_sel, 0);
        end
        $display("txn addr=%h wr=%0d size=%0d waits=%0d slave=%0d tmo=%0d rdata=%h",
                 addr, wr, size, waits, idx, tmo, m_rdata);
        // A request visible only during the response cycle must be ignored.
        m_req = 1'b1; m_addr = $urandom; s_ready = '1;
        @(negedge clk);
        m_req = 1'b0; s_ready = '0;
        chk("idle_ready", m_ready, 0);
        chk("idle_err", m_err, 0);
        chk("idle_sel", s_sel, 0);
        chk("hold_rdata", m_rdata, model_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        rst_n = 1'b0; m_req = 1'b0; m_addr = '0; m_wdata = '0; m_write = 1'b0; m_size = 2'b00;
        s_rdata = '0; s_ready = '0;
        @(negedge clk);
        m_req = 1'b1; m_addr = 32'h1000_0000;
        @(negedge clk);
        chk("rst_ready", m_ready, 0);
        chk("rst_err", m_err, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_sel", s_sel, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_write", s_write, 0);
        chk("rst_size", s_size, 0);
        m_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(32'h1000_0004, 32'h0, 1'b0, 2'b10, 0);
        do_txn(32'h1001_0010, 32'h1234_5678, 1'b1, 2'b10, 3);
        do_txn(32'h3000_0000, 32'h0, 1'b0, 2'b00, 0);
        do_txn(32'h1000_0000, 32'h0, 1'b0, 2'b01, 1);
        do_txn(32'h0000_0040, 32'hCAFE_F00D, 1'b1, 2'b00, 2);
`ifdef BUS_TIMEOUT_EN
        do_txn(32'h0000_0100, 32'h0, 1'b0, 2'b10, 1000);
        do_txn(32'h0000_0104, 32'h0, 1'b0, 2'b10, TIMEOUT - 1);
        do_txn(32'h0000_0108, 32'h0, 1'b0, 2'b10, TIMEOUT);
`endif

        // Reset while a mapped access is waiting.
        m_req = 1'b1; m_addr = 32'h0000_0200; m_wdata = 32'h5555_AAAA; m_write = 1'b1; m_size = 2'b10;
        s_ready = '0;
        @(negedge clk);
        chk("pre_rst_sel", s_sel, 3'b001);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", m_ready, 0);
        chk("mid_rst_err", m_err, 0);
        chk("mid_rst_rdata", m_rdata, 0);
        chk("mid_rst_sel", s_sel, 0);
        chk("mid_rst_addr", s_addr, 0);
        chk("mid_rst_wdata", s_wdata, 0);
        chk("mid_rst_write", s_write, 0);
        rst_n = 1'b1; m_req = 1'b0; s_ready = '1;
        model_rdata = '0;
        @(negedge clk);
        chk("post_rst_sel", s_sel, 0);
        chk("post_rst_ready", m_ready, 0);
        s_ready = '0;
        do_txn(32'h1000_0020, 32'h0, 1'b0, 2'b10, 2);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(3, 0))
                0:       a = {16'h0000, 16'($urandom)};
                1:       a = {16'h1000, 16'($urandom)};
                2:       a = {4'h1, 28'($urandom)};
                default: a = $urandom;
            endcase
            do_txn(a, $urandom, 1'($urandom), 2'($urandom_range(2, 0)), int'($urandom_range(5, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
